coin_vend_ctrl: RTL and testbench
=================================

# coin_vend_ctrl

Parametrised coin-operated vending/charging controller, the successor to the fixed-price top-level FSM. It accepts two coin denominations, holds a running credit with a programmable ceiling, and serves two price levels. It computes change arithmetically rather than from a lookup, and auto-returns to idle after a change-display hold. Outputs feed the 7-segment driver (credit/change values) and the panel LEDs (state, busy, overflow).

## Interface
- AMT_W, 6: width of all amount buses; unit = 0.5 currency.
- COIN_A_VAL, 2: value of small coin (1.0).
- COIN_B_VAL, 20: value of large coin (10.0).
- PRICE_HI, 10: high-tier price (5.0).
- PRICE_LO, 5: low-tier price (2.5).
- MAX_CREDIT, 20: credit ceiling; must be < 2^AMT_W.
- HOLD_CYC, 50000: cycles CHANGE state is held before auto-return.
- HOLD_W, 16: width of the hold counter.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- power  in  1  level; 0 forces OFF synchronously.
- start  in  1  pulse; claim the machine.
- coin_a, coin_b  in  1 each  single-cycle debounced coin pulses.
- sel_hi, sel_lo  in  1 each  single-cycle product-select pulses.
- cancel  in  1  pulse; abort and refund.
- refresh  in  1  pulse; early exit from CHANGE.
- state  out  3  OFF=0, IDLE=1, CREDIT=2, DISPENSE=3, CHANGE=4.
- work  out  1  high in every state except OFF.
- busy  out  1  high in CREDIT, DISPENSE, CHANGE.
- credit  out  AMT_W  current accumulated credit.
- change  out  AMT_W  refund amount; valid while change_valid.
- change_valid  out  1  high throughout CHANGE.
- vend_hi, vend_lo  out  1 each  one-cycle dispense strobe.
- coin_reject  out  1  one-cycle pulse; a coin was refused.
- overflow  out  1  sticky; a coin was refused at the ceiling.
- short_pay  out  1  one-cycle pulse; select with insufficient credit.

## Operation
- All outputs are registered. Reset value of every output is 0, and state=OFF.
- power=0 in any state: next cycle state=OFF. All outputs clear and credit is discarded.
- OFF -> IDLE when power=1.
- IDLE -> CREDIT on start. credit=0, overflow=0. All other inputs are ignored in IDLE.
- CREDIT, input priority: cancel > sel_hi > sel_lo > coin_b > coin_a.
  - Coin accept: sum computed in AMT_W+1 bits. If sum ≤ MAX_CREDIT, credit=sum. Otherwise credit is unchanged, coin_reject=1, overflow=1.
  - coin_a and coin_b in the same cycle: coin_b is evaluated and coin_a is rejected (coin_reject=1; overflow unaffected by the coin_a rejection).
  - Coin coincident with a select or cancel: the coin is rejected, coin_reject=1.
  - sel_x with credit ≥ PRICE_x: go to DISPENSE, change=credit−PRICE_x, and the matching vend_x strobe fires.
  - sel_x with credit < PRICE_x: short_pay=1 and the block stays in CREDIT.
  - sel_hi and sel_lo together: only sel_hi is evaluated.
  - cancel with credit>0: go to CHANGE, change=credit.
  - cancel with credit=0: go to IDLE.
- DISPENSE: lasts exactly one cycle.
  - credit cleared.
  - If change>0, go to CHANGE; otherwise go to IDLE.
- CHANGE:
  - change_valid=1 and the hold counter runs.
  - Exit to IDLE on refresh, or when the counter reaches HOLD_CYC−1.
  - On exit, change and change_valid clear and overflow clears.
- start, coins and selects outside the states named above are ignored, with no pulses.

## Timing
- Coin pulse at edge N: credit is updated, or coin_reject/overflow asserted, at edge N+1.
- Select at edge N (sufficient credit): at N+1, state=DISPENSE, vend_x=1 and change is valid in value. At N+2, state=CHANGE with change_valid=1 (or IDLE if change=0), and vend_x=0.
- Cancel at edge N: at N+1, state=CHANGE, change_valid=1.
- CHANGE entered at edge M with no refresh: IDLE at edge M+HOLD_CYC.
- Async reset deassertion: OFF for at least one cycle, then IDLE on the next edge if power=1.
- Reset asserted mid-transaction: everything clears immediately, and no vend or refund is emitted.

## Test plan
- Basic high purchase. Stimulus: power=1, start, coin_b. Response: credit=20. Then sel_hi gives vend_hi for one cycle, then CHANGE with change=10, then IDLE after HOLD_CYC cycles.
- Low purchase with small coins:
  - Three coin_a give credit=6.
  - sel_lo at credit=4 produces short_pay and the block stays in CREDIT.
  - sel_lo at credit=6 produces vend_lo and change=1.
- Ceiling. Stimulus: coin_b (credit=20), then coin_a. Response: coin_reject pulse, overflow=1, credit stays 20. Then cancel gives change=20, and overflow clears on exit.
- Simultaneous events:
  - coin_a+coin_b in the same cycle: credit+=20 and coin_reject=1.
  - sel_hi+sel_lo at credit=20: vend_hi only, change=10.
- Exact pay and zero cancel:
  - Credit=10, sel_hi: DISPENSE then directly IDLE, with change_valid never high.
  - cancel at credit=0 goes straight to IDLE.
- Disruptions:
  - refresh in CHANGE exits on the next edge.
  - power=0 in CREDIT with credit=8: OFF next cycle, all outputs 0.
  - reset asserted asynchronously in DISPENSE: outputs cleared before the next edge.

Source files
------------

// File: rtl/coin_vend_ctrl_if.sv
// Panel-side bus of the coin vending controller: buttons and coin pulses in,
// display/LED values out.
interface coin_vend_ctrl_if #(
   parameter int AMT_W = 6
);
   logic             power;
   logic             start;
   logic             coin_a;
   logic             coin_b;
   logic             sel_hi;
   logic             sel_lo;
   logic             cancel;
   logic             refresh;
   logic [2:0]       state;
   logic             work;
   logic             busy;
   logic [AMT_W-1:0] credit;
   logic [AMT_W-1:0] change;
   logic             change_valid;
   logic             vend_hi;
   logic             vend_lo;
   logic             coin_reject;
   logic             overflow;
   logic             short_pay;

   modport master (
      output power, start, coin_a, coin_b, sel_hi, sel_lo, cancel, refresh,
      input  state, work, busy, credit, change, change_valid,
             vend_hi, vend_lo, coin_reject, overflow, short_pay
   );

   modport slave (
      input  power, start, coin_a, coin_b, sel_hi, sel_lo, cancel, refresh,
      output state, work, busy, credit, change, change_valid,
             vend_hi, vend_lo, coin_reject, overflow, short_pay
   );
endinterface

// File: rtl/coin_vend_ctrl.sv
// Coin-operated vending controller: two coin values, credit ceiling, two prices,
// arithmetic change and a timed change display. Every output is a register.
module coin_vend_ctrl #(
   parameter int AMT_W      = 6,
   parameter int COIN_A_VAL = 2,
   parameter int COIN_B_VAL = 20,
   parameter int PRICE_HI   = 10,
   parameter int PRICE_LO   = 5,
   parameter int MAX_CREDIT = 20,
   parameter int HOLD_CYC   = 50000,
   parameter int HOLD_W     = 16
) (
   input logic               clk,
   input logic               reset,
   coin_vend_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      OFF      = 3'd0,
      IDLE     = 3'd1,
      CREDIT   = 3'd2,
      DISPENSE = 3'd3,
      CHANGE   = 3'd4
   } state_t;

   localparam logic [AMT_W:0]    COIN_A_EXT = (AMT_W+1)'(COIN_A_VAL);
   localparam logic [AMT_W:0]    COIN_B_EXT = (AMT_W+1)'(COIN_B_VAL);
   localparam logic [AMT_W:0]    MAX_EXT    = (AMT_W+1)'(MAX_CREDIT);
   localparam logic [AMT_W-1:0]  PRICE_HI_V = AMT_W'(PRICE_HI);
   localparam logic [AMT_W-1:0]  PRICE_LO_V = AMT_W'(PRICE_LO);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);

   state_t            state, state_nxt;
   logic [AMT_W-1:0]  credit, credit_nxt;
   logic [AMT_W-1:0]  change, change_nxt;
   logic [HOLD_W-1:0] hold, hold_nxt;
   logic              overflow, overflow_nxt;
   logic              vend_hi, vend_hi_nxt;
   logic              vend_lo, vend_lo_nxt;
   logic              coin_reject, coin_reject_nxt;
   logic              short_pay, short_pay_nxt;
   logic              work, busy, change_valid;
   logic [AMT_W:0]    sum_a, sum_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= OFF;
         credit       <= '0;
         change       <= '0;
         hold         <= '0;
         overflow     <= 1'b0;
         vend_hi      <= 1'b0;
         vend_lo      <= 1'b0;
         coin_reject  <= 1'b0;
         short_pay    <= 1'b0;
         work         <= 1'b0;
         busy         <= 1'b0;
         change_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         credit       <= credit_nxt;
         change       <= change_nxt;
         hold         <= hold_nxt;
         overflow     <= overflow_nxt;
         vend_hi      <= vend_hi_nxt;
         vend_lo      <= vend_lo_nxt;
         coin_reject  <= coin_reject_nxt;
         short_pay    <= short_pay_nxt;
         work         <= (state_nxt != OFF);
         busy         <= (state_nxt == CREDIT) || (state_nxt == DISPENSE) ||
                         (state_nxt == CHANGE);
         change_valid <= (state_nxt == CHANGE);
      end
   end

   // Sums carry one extra bit so a coin pushing past the ceiling cannot wrap.
   always_comb begin
      state_nxt       = state;
      credit_nxt      = credit;
      change_nxt      = change;
      overflow_nxt    = overflow;
      vend_hi_nxt     = 1'b0;
      vend_lo_nxt     = 1'b0;
      coin_reject_nxt = 1'b0;
      short_pay_nxt   = 1'b0;
      sum_a           = {1'b0, credit} + COIN_A_EXT;
      sum_b           = {1'b0, credit} + COIN_B_EXT;

      case (state)
         OFF: begin
            if (bus.power) state_nxt = IDLE;
         end
         IDLE: begin
            if (bus.start) begin
               state_nxt    = CREDIT;
               credit_nxt   = '0;
               overflow_nxt = 1'b0;
            end
         end
         CREDIT: begin
            if (bus.cancel) begin
               coin_reject_nxt = bus.coin_a | bus.coin_b;
               if (credit != '0) begin
                  state_nxt  = CHANGE;
                  change_nxt = credit;
                  credit_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (bus.sel_hi) begin
               coin_reject_nxt = bus.coin_a | bus.coin_b;
               if (credit >= PRICE_HI_V) begin
                  state_nxt   = DISPENSE;
                  change_nxt  = credit - PRICE_HI_V;
                  vend_hi_nxt = 1'b1;
               end else begin
                  short_pay_nxt = 1'b1;
               end
            end else if (bus.sel_lo) begin
               coin_reject_nxt = bus.coin_a | bus.coin_b;
               if (credit >= PRICE_LO_V) begin
                  state_nxt   = DISPENSE;
                  change_nxt  = credit - PRICE_LO_V;
                  vend_lo_nxt = 1'b1;
               end else begin
                  short_pay_nxt = 1'b1;
               end
            end else if (bus.coin_b) begin
               coin_reject_nxt = bus.coin_a;
               if (sum_b <= MAX_EXT) begin
                  credit_nxt = sum_b[AMT_W-1:0];
               end else begin
                  coin_reject_nxt = 1'b1;
                  overflow_nxt    = 1'b1;
               end
            end else if (bus.coin_a) begin
               if (sum_a <= MAX_EXT) begin
                  credit_nxt = sum_a[AMT_W-1:0];
               end else begin
                  coin_reject_nxt = 1'b1;
                  overflow_nxt    = 1'b1;
               end
            end
         end
         DISPENSE: begin
            credit_nxt = '0;
            state_nxt  = (change != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            if (bus.refresh || (hold == HOLD_LAST)) begin
               state_nxt    = IDLE;
               change_nxt   = '0;
               overflow_nxt = 1'b0;
            end
         end
         default: state_nxt = OFF;
      endcase

      // Losing power wins over everything and throws the credit away.
      if (!bus.power) begin
         state_nxt       = OFF;
         credit_nxt      = '0;
         change_nxt      = '0;
         overflow_nxt    = 1'b0;
         vend_hi_nxt     = 1'b0;
         vend_lo_nxt     = 1'b0;
         coin_reject_nxt = 1'b0;
         short_pay_nxt   = 1'b0;
      end

      hold_nxt = ((state == CHANGE) && (state_nxt == CHANGE)) ? hold + 1'b1 : '0;
   end

   assign bus.state        = state;
   assign bus.work         = work;
   assign bus.busy         = busy;
   assign bus.credit       = credit;
   assign bus.change       = change;
   assign bus.change_valid = change_valid;
   assign bus.vend_hi      = vend_hi;
   assign bus.vend_lo      = vend_lo;
   assign bus.coin_reject  = coin_reject;
   assign bus.overflow     = overflow;
   assign bus.short_pay    = short_pay;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Table-driven bench for coin_vend_ctrl with a short change hold; expected
// register values are queued when a step is driven and popped after the edge.
module tb_coin_vend_ctrl;

   localparam int AMT_W    = 6;
   localparam int HOLD_CYC = 4;

   localparam logic [7:0] P  = 8'h80, ST = 8'h40, CA = 8'h20, CB = 8'h10;
   localparam logic [7:0] SH = 8'h08, SL = 8'h04, CN = 8'h02, RF = 8'h01;

   localparam logic [7:0] W  = 8'h80, B  = 8'h40, CV = 8'h20, VH = 8'h10;
   localparam logic [7:0] VL = 8'h08, RJ = 8'h04, OV = 8'h02, SP = 8'h01;
   localparam logic [7:0] WB = W | B;

   localparam logic [2:0] S_OFF = 3'd0, S_IDLE = 3'd1, S_CREDIT = 3'd2;
   localparam logic [2:0] S_DISP = 3'd3, S_CHG = 3'd4;

   typedef struct packed {
      logic [2:0]       state;
      logic [AMT_W-1:0] credit;
      logic [AMT_W-1:0] change;
      logic [7:0]       flags;
   } exp_t;

   typedef struct {
      string      name;
      logic [7:0] stim;
      exp_t       exp;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   vec_t  vecs[$];
   exp_t  expq[$];
   string nameq[$];
   int    checks = 0;
   int    fails  = 0;

   always #5 clk = ~clk;

   coin_vend_ctrl_if #(.AMT_W(AMT_W)) bus ();

   coin_vend_ctrl #(
      .AMT_W(AMT_W),
      .HOLD_CYC(HOLD_CYC),
      .HOLD_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   function automatic vec_t mk(string name, logic [7:0] stim, logic [2:0] st,
                               int cr, int ch, logic [7:0] fl);
      vec_t v;
      v.name       = name;
      v.stim       = stim;
      v.exp.state  = st;
      v.exp.credit = AMT_W'(cr);
      v.exp.change = AMT_W'(ch);
      v.exp.flags  = fl;
      return v;
   endfunction

   function automatic exp_t sampleDut();
      exp_t s;
      s.state  = bus.state;
      s.credit = bus.credit;
      s.change = bus.change;
      s.flags  = {bus.work, bus.busy, bus.change_valid, bus.vend_hi, bus.vend_lo,
                  bus.coin_reject, bus.overflow, bus.short_pay};
      return s;
   endfunction

   task automatic driveInputs(input logic [7:0] stim);
      {bus.power, bus.start, bus.coin_a, bus.coin_b,
       bus.sel_hi, bus.sel_lo, bus.cancel, bus.refresh} = stim;
   endtask

   task automatic applyStimulus(input vec_t v);
      driveInputs(v.stim);
      expq.push_back(v.exp);
      nameq.push_back(v.name);
   endtask

   task automatic expectOnly(input string name, input exp_t e);
      expq.push_back(e);
      nameq.push_back(name);
   endtask

   task automatic checkOutput();
      exp_t  want, got;
      string nm;
      checks++;
      if (expq.size() == 0) begin
         fails++;
         $display("[TB] FAIL scoreboard: DUT sampled with no expected entry queued");
         return;
      end
      want = expq.pop_front();
      nm   = nameq.pop_front();
      got  = sampleDut();
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s: got state=%0d credit=%0d change=%0d flags=%b, expected state=%0d credit=%0d change=%0d flags=%b",
                  nm, got.state, got.credit, got.change, got.flags,
                  want.state, want.credit, want.change, want.flags);
      end
   endtask

   task automatic runStep(input vec_t v);
      @(negedge clk);
      applyStimulus(v);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      exp_t zero;
      zero = '0;

      // basic high purchase with change and timed return
      vecs.push_back(mk("power_on",      P,      S_IDLE,   0,  0, W));
      vecs.push_back(mk("start",         P|ST,   S_CREDIT, 0,  0, WB));
      vecs.push_back(mk("coin_b",        P|CB,   S_CREDIT, 20, 0, WB));
      vecs.push_back(mk("sel_hi",        P|SH,   S_DISP,   20, 10, WB|VH));
      vecs.push_back(mk("to_change",     P,      S_CHG,    0,  10, WB|CV));
      vecs.push_back(mk("hold_1",        P,      S_CHG,    0,  10, WB|CV));
      vecs.push_back(mk("hold_2",        P,      S_CHG,    0,  10, WB|CV));
      vecs.push_back(mk("hold_3",        P,      S_CHG,    0,  10, WB|CV));
      vecs.push_back(mk("hold_expire",   P,      S_IDLE,   0,  0, W));
      // low purchase with small coins, short pay, refresh exit
      vecs.push_back(mk("start2",        P|ST,   S_CREDIT, 0,  0, WB));
      vecs.push_back(mk("coin_a_1",      P|CA,   S_CREDIT, 2,  0, WB));
      vecs.push_back(mk("coin_a_2",      P|CA,   S_CREDIT, 4,  0, WB));
      vecs.push_back(mk("short_pay_lo",  P|SL,   S_CREDIT, 4,  0, WB|SP));
      vecs.push_back(mk("coin_a_3",      P|CA,   S_CREDIT, 6,  0, WB));
      vecs.push_back(mk("sel_lo",        P|SL,   S_DISP,   6,  1, WB|VL));
      vecs.push_back(mk("change_lo",     P,      S_CHG,    0,  1, WB|CV));
      vecs.push_back(mk("refresh_exit",  P|RF,   S_IDLE,   0,  0, W));
      // ceiling refusal, sticky overflow, cancel refund
      vecs.push_back(mk("start3",        P|ST,   S_CREDIT, 0,  0, WB));
      vecs.push_back(mk("coin_b_max",    P|CB,   S_CREDIT, 20, 0, WB));
      vecs.push_back(mk("coin_a_over",   P|CA,   S_CREDIT, 20, 0, WB|RJ|OV));
      vecs.push_back(mk("ovf_sticky",    P,      S_CREDIT, 20, 0, WB|OV));
      vecs.push_back(mk("cancel_refund", P|CN,   S_CHG,    0,  20, WB|CV|OV));
      vecs.push_back(mk("ovf_clear",     P|RF,   S_IDLE,   0,  0, W));
      // simultaneous events
      vecs.push_back(mk("start4",        P|ST,   S_CREDIT, 0,  0, WB));
      vecs.push_back(mk("coin_ab",       P|CA|CB, S_CREDIT, 20, 0, WB|RJ));
      vecs.push_back(mk("sel_both",      P|SH|SL, S_DISP,   20, 10, WB|VH));
      vecs.push_back(mk("change_both",   P,      S_CHG,    0,  10, WB|CV));
      vecs.push_back(mk("exit_both",     P|RF,   S_IDLE,   0,  0, W));
      vecs.push_back(mk("start5",        P|ST,   S_CREDIT, 0,  0, WB));
      vecs.push_back(mk("coin_a_s5",     P|CA,   S_CREDIT, 2,  0, WB));
      vecs.push_back(mk("sel_with_coin", P|SL|CA, S_CREDIT, 2, 0, WB|RJ|SP));
      vecs.push_back(mk("cancel_w_coin", P|CN|CA, S_CHG,   0,  2, WB|CV|RJ));
      vecs.push_back(mk("exit_s5",       P|RF,   S_IDLE,   0,  0, W));
      // inputs ignored in IDLE, exact pay, zero cancel
      vecs.push_back(mk("idle_ignore",   P|CA|SH|CN, S_IDLE, 0, 0, W));
      vecs.push_back(mk("start6",        P|ST,   S_CREDIT, 0,  0, WB));
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk($sformatf("exact_coin_%0d", i), P|CA, S_CREDIT, 2*i, 0, WB));
      vecs.push_back(mk("exact_sel_hi",  P|SH,   S_DISP,   10, 0, WB|VH));
      vecs.push_back(mk("exact_idle",    P,      S_IDLE,   0,  0, W));
      vecs.push_back(mk("start7",        P|ST,   S_CREDIT, 0,  0, WB));
      vecs.push_back(mk("cancel_zero",   P|CN,   S_IDLE,   0,  0, W));
      // power loss in CREDIT
      vecs.push_back(mk("start8",        P|ST,   S_CREDIT, 0,  0, WB));
      for (int i = 1; i <= 4; i++)
         vecs.push_back(mk($sformatf("pwr_coin_%0d", i), P|CA, S_CREDIT, 2*i, 0, WB));
      vecs.push_back(mk("power_loss",    8'h00,  S_OFF,    0,  0, 8'h00));
      vecs.push_back(mk("power_back",    P,      S_IDLE,   0,  0, W));
      vecs.push_back(mk("start9",        P|ST,   S_CREDIT, 0,  0, WB));
      vecs.push_back(mk("coin_b9",       P|CB,   S_CREDIT, 20, 0, WB));
      vecs.push_back(mk("sel_hi9",       P|SH,   S_DISP,   20, 10, WB|VH));

      driveInputs(8'h00);
      #1;
      expectOnly("reset_state", zero);
      checkOutput();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) runStep(vecs[i]);

      // asynchronous reset while in DISPENSE clears outputs before the next edge
      #2;
      driveInputs(P);
      reset = 1'b0;
      #1;
      expectOnly("async_reset_dispense", zero);
      checkOutput();
      @(negedge clk);
      reset = 1'b1;
      #1;
      expectOnly("off_after_release", zero);
      checkOutput();
      @(posedge clk);
      #1;
      begin
         exp_t idle_e;
         idle_e       = '0;
         idle_e.state = S_IDLE;
         idle_e.flags = W;
         expectOnly("idle_after_release", idle_e);
      end
      checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
